// File: rtl/keccak_rho_engine.sv
// Keccak rho-step engine: rotates each of the 25 lanes of a captured state by
// its fixed rho offset (or the inverse rotation), LPC lanes per clock, and
// holds the rotated state in a registered output buffer until the next start.
module keccak_rho_engine #(
    parameter int LANE_W = 64,   // 1, 2, 4, 8, 16, 32 or 64
    parameter int LPC    = 1     // 1, 5 or 25 lanes per cycle
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  inverse,
    input  logic [25*LANE_W-1:0]  state_in,
    output logic [25*LANE_W-1:0]  state_out,
    output logic                  busy,
    output logic                  done
);

    localparam int         NGRP     = 25 / LPC;
    localparam logic [4:0] LAST_G   = 5'(NGRP - 1);
    // Offsets reduced mod LANE_W by keeping only the low log2(LANE_W) bits.
    localparam logic [5:0] OFF_MASK = 6'(LANE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        g_q, g_d;
    logic              load;
    logic              inv_q;
    logic [LANE_W-1:0] buf_q [25];
    logic [LANE_W-1:0] out_q [25];
    logic [4:0]        lane_idx [LPC];
    logic [LANE_W-1:0] rot_lane [LPC];

    // Rho offset ROM, indexed by lane i = x + 5y.
    function automatic logic [5:0] rho_rom(input logic [4:0] i);
        logic [5:0] r;
        case (i)
            5'd0:  r = 6'd0;   5'd1:  r = 6'd1;   5'd2:  r = 6'd62;
            5'd3:  r = 6'd28;  5'd4:  r = 6'd27;  5'd5:  r = 6'd36;
            5'd6:  r = 6'd44;  5'd7:  r = 6'd6;   5'd8:  r = 6'd55;
            5'd9:  r = 6'd20;  5'd10: r = 6'd3;   5'd11: r = 6'd10;
            5'd12: r = 6'd43;  5'd13: r = 6'd25;  5'd14: r = 6'd39;
            5'd15: r = 6'd41;  5'd16: r = 6'd45;  5'd17: r = 6'd15;
            5'd18: r = 6'd21;  5'd19: r = 6'd8;   5'd20: r = 6'd18;
            5'd21: r = 6'd2;   5'd22: r = 6'd61;  5'd23: r = 6'd56;
            5'd24: r = 6'd14;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Barrel rotate via a doubled lane: the upper half of a left shift is a
    // rotate-left, the lower half of a right shift is a rotate-right.
    function automatic logic [LANE_W-1:0] rotate(input logic [LANE_W-1:0] x,
                                                 input logic [5:0]        e,
                                                 input logic              inv);
        logic [2*LANE_W-1:0] dbl;
        logic [LANE_W-1:0]   res;
        dbl = {x, x};
        if (inv) begin
            dbl = dbl >> e;
            res = dbl[LANE_W-1:0];
        end else begin
            dbl = dbl << e;
            res = dbl[2*LANE_W-1:LANE_W];
        end
        return res;
    endfunction

    // One rotator per lane slot of the current group.
    for (genvar gi = 0; gi < LPC; gi++) begin : g_rot
        assign lane_idx[gi] = 5'(int'(g_q) * LPC + gi);
        assign rot_lane[gi] = rotate(buf_q[lane_idx[gi]],
                                     rho_rom(lane_idx[gi]) & OFF_MASK,
                                     inv_q);
    end

    for (genvar gi = 0; gi < 25; gi++) begin : g_pack
        assign state_out[gi*LANE_W +: LANE_W] = out_q[gi];
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // Next-state logic: DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    g_d     = 5'd0;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (g_q == LAST_G) begin
                    state_d = S_DONE;
                    g_d     = 5'd0;
                end else begin
                    g_d = g_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: FSM state, group counter, latched direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            g_q     <= 5'd0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            if (load) inv_q <= inverse;
        end
    end

    // Input buffer: captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) buf_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 25; i++) buf_q[i] <= state_in[i*LANE_W +: LANE_W];
        end
    end

    // Output register: one lane group written per RUN cycle, others held.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) out_q[i] <= '0;
        end else if (state_q == S_RUN) begin
            for (int k = 0; k < LPC; k++) out_q[lane_idx[k]] <= rot_lane[k];
        end
    end

endmodule

// File: tb/tb_keccak_rho_engine.sv
// Directed bench for keccak_rho_engine across four parameter sets.
module tb_keccak_rho_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: LANE_W=64 LPC=1
    logic a_start = 0, a_inverse = 0, a_busy, a_done;
    logic [1599:0] a_state_in = '0, a_state_out;
    // B: LANE_W=64 LPC=5
    logic b_start = 0, b_inverse = 0, b_busy, b_done;
    logic [1599:0] b_state_in = '0, b_state_out;
    // C: LANE_W=8 LPC=25
    logic c_start = 0, c_inverse = 0, c_busy, c_done;
    logic [199:0] c_state_in = '0, c_state_out;
    // D: LANE_W=1 LPC=5
    logic d_start = 0, d_inverse = 0, d_busy, d_done;
    logic [24:0] d_state_in = '0, d_state_out;

    keccak_rho_engine #(.LANE_W(64), .LPC(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .inverse(a_inverse),
        .state_in(a_state_in), .state_out(a_state_out), .busy(a_busy), .done(a_done));
    keccak_rho_engine #(.LANE_W(64), .LPC(5)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .inverse(b_inverse),
        .state_in(b_state_in), .state_out(b_state_out), .busy(b_busy), .done(b_done));
    keccak_rho_engine #(.LANE_W(8), .LPC(25)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .inverse(c_inverse),
        .state_in(c_state_in), .state_out(c_state_out), .busy(c_busy), .done(c_done));
    keccak_rho_engine #(.LANE_W(1), .LPC(5)) u_d (
        .clk(clk), .rst(rst), .start(d_start), .inverse(d_inverse),
        .state_in(d_state_in), .state_out(d_state_out), .busy(d_busy), .done(d_done));

    int total = 0;
    int bad   = 0;
    int roff[25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state64(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        for (int i = 0; i < 25; i++)
            chk($sformatf("%s_lane%0d", tag, i), obs[i*64 +: 64], exp[i*64 +: 64]);
    endtask

    function automatic logic cur_done(input int w);
        case (w)
            0: return a_done;
            1: return b_done;
            2: return c_done;
            default: return d_done;
        endcase
    endfunction

    // Called right after the start edge; lat = cycle index of done (start cycle = 0).
    task automatic wait_done(input int w, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (cur_done(w)) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    // Bit-level reference rotation of a 64-bit-lane state.
    function automatic logic [1599:0] exp_rho(input logic [1599:0] s, input logic inv);
        logic [1599:0] o;
        o = '0;
        for (int i = 0; i < 25; i++)
            for (int j = 0; j < 64; j++) begin
                if (!inv) o[i*64 + ((j + roff[i]) % 64)] = s[i*64 + j];
                else      o[i*64 + j] = s[i*64 + ((j + roff[i]) % 64)];
            end
        return o;
    endfunction

    function automatic logic [1599:0] gen_state(input int seed);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++)
            s[i*64 +: 64] = (64'h9E3779B97F4A7C15 * 64'(seed * 25 + i + 1)) ^ 64'(seed);
        return s;
    endfunction

    function automatic logic inv_at(input int m);
        return (m % 4) >= 2;
    endfunction

    initial begin
        int lat;
        int seen;
        logic [1599:0] e1, orig, fwd, sa, sb, sc;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_out_or", 64'(|a_state_out), 64'd0);
        $display("txn reset: busy=%0b done=%0b", a_busy, a_done);

        // Basic forward rotation, LANE_W=64 LPC=1
        a_state_in = '0;
        a_state_in[64 +: 64]  = 64'h1;
        a_state_in[128 +: 64] = 64'h1;
        a_inverse = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t1_busy_rise", 64'(a_busy), 64'd1);
        wait_done(0, 40, lat);
        chk("t1_latency", 64'(lat), 64'd26);
        chk("t1_busy_at_done", 64'(a_busy), 64'd0);
        e1 = '0;
        e1[64 +: 64]  = 64'h2;
        e1[128 +: 64] = 64'h4000000000000000;
        chk_state64("t1", a_state_out, e1);
        $display("txn t1: lat=%0d lane1=%h lane2=%h", lat, a_state_out[64 +: 64], a_state_out[128 +: 64]);
        tick();
        chk("t1_done_one_cycle", 64'(a_done), 64'd0);

        // Forward then inverse round trip, LANE_W=64 LPC=5
        orig = gen_state(1);
        b_state_in = orig;
        b_inverse = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_state_in = '0;
        wait_done(1, 20, lat);
        chk("t2_fwd_latency", 64'(lat), 64'd6);
        fwd = b_state_out;
        chk_state64("t2_fwd", fwd, exp_rho(orig, 1'b0));
        $display("txn t2 fwd: lat=%0d lane0=%h", lat, fwd[63:0]);
        tick();
        b_state_in = fwd;
        b_inverse = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_inverse = 1'b0;
        wait_done(1, 20, lat);
        chk("t2_inv_latency", 64'(lat), 64'd6);
        chk_state64("t2_inv", b_state_out, orig);
        $display("txn t2 inv: lat=%0d lane0=%h", lat, b_state_out[63:0]);

        // Narrow lanes, full parallel: LANE_W=8 LPC=25
        c_state_in = '0;
        c_state_in[16 +: 8]  = 8'h01;
        c_state_in[192 +: 8] = 8'h80;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        wait_done(2, 10, lat);
        chk("t3_latency", 64'(lat), 64'd2);
        chk("t3_lane2", 64'(c_state_out[16 +: 8]), 64'h40);
        chk("t3_lane24", 64'(c_state_out[192 +: 8]), 64'h20);
        sc = 1600'(c_state_out);
        sc[16 +: 8]  = 8'h00;
        sc[192 +: 8] = 8'h00;
        chk("t3_others_zero", 64'(|sc), 64'd0);
        $display("txn t3: lat=%0d lane2=%h lane24=%h", lat, c_state_out[16 +: 8], c_state_out[192 +: 8]);

        // Single-bit lanes: rotation is the identity
        d_state_in = 25'h1555555;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        wait_done(3, 20, lat);
        chk("t4_latency", 64'(lat), 64'd6);
        chk("t4_identity", 64'(d_state_out), 64'h1555555);
        $display("txn t4: lat=%0d out=%h", lat, d_state_out);

        // start held high, data changing every cycle, LPC=5
        tick();
        b_start = 1'b1;
        b_state_in = gen_state(10);
        b_inverse = inv_at(0);
        for (int k = 0; k < 18; k++) begin
            tick();
            chk($sformatf("t6_done_e%0d", k), 64'(b_done), 64'((k % 6) == 5));
            if ((k % 6) == 5) begin
                chk_state64($sformatf("t6_op%0d", k / 6), b_state_out,
                            exp_rho(gen_state(10 + k - 5), inv_at(k - 5)));
                $display("txn t6 op%0d: lane3=%h", k / 6, b_state_out[192 +: 64]);
            end
            if (k == 17) b_start = 1'b0;
            b_state_in = gen_state(10 + k + 1);
            b_inverse  = inv_at(k + 1);
        end
        tick();
        chk("t6_idle_after", 64'(b_busy), 64'd0);

        // start during RUN is ignored, LPC=1
        sa = gen_state(20);
        sb = gen_state(21);
        a_state_in = sa;
        a_inverse = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (a_done) begin
                lat = k + 1;
                break;
            end
            if (k == 9) begin
                a_start = 1'b1;
                a_state_in = sb;
                a_inverse = 1'b1;
            end
            if (k == 10) a_start = 1'b0;
        end
        a_inverse = 1'b0;
        chk("t5_latency", 64'(lat), 64'd26);
        chk_state64("t5_ignored", a_state_out, exp_rho(sa, 1'b0));
        tick();
        chk("t5_no_restart", 64'(a_busy), 64'd0);
        $display("txn t5 ignore: lat=%0d lane1=%h", lat, a_state_out[64 +: 64]);

        // Reset aborts an operation mid-flight
        sc = gen_state(30);
        a_state_in = sc;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (14) tick();
        chk("t5_busy_before_rst", 64'(a_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_busy", 64'(a_busy), 64'd0);
        chk("t5_rst_done", 64'(a_done), 64'd0);
        chk_state64("t5_rst_out", a_state_out, '0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (a_done) seen++;
        end
        chk("t5_no_done_after_rst", 64'(seen), 64'd0);
        $display("txn t5 abort: busy=%0b dones=%0d", a_busy, seen);

        // rst and start together: reset wins
        a_state_in = sa;
        a_start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_start = 1'b0;
        chk("t7_rst_wins_busy", 64'(a_busy), 64'd0);
        tick();
        chk("t7_still_idle", 64'(a_busy), 64'd0);
        $display("txn t7 rst+start: busy=%0b", a_busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
